// File: rtl/operand_fetch_pkg.sv
// -----------------------------------------------------------------------------
// operand_fetch_pkg
// Shared defaults for the register-file read side. The address/data widths and
// depth are the same values register_file is built with, so both blocks agree
// on the register map without repeating the numbers.
//
// Contents:
//   OF_ADDR_WIDTH, OF_WIDTH, OF_DEPTH  default register-file geometry
//   OF_ZERO_REG                        register 0 hard-wired to zero
//   busy_op_e / busy_op_sel            per-register scoreboard update decision
// -----------------------------------------------------------------------------
package operand_fetch_pkg;

   localparam int OF_ADDR_WIDTH = 5;
   localparam int OF_WIDTH      = 32;
   localparam int OF_DEPTH      = 1 << OF_ADDR_WIDTH;
   localparam bit OF_ZERO_REG   = 1'b1;

   typedef enum logic [1:0] {
      BUSY_HOLD  = 2'd0,
      BUSY_SET   = 2'd1,
      BUSY_CLEAR = 2'd2,
      BUSY_FLUSH = 2'd3
   } busy_op_e;

   // Flush beats a new set, which beats a writeback clear. Letting the set win
   // over a same-register clear keeps the newer write tracked.
   function automatic busy_op_e busy_op_sel(input logic flush_all,
                                            input logic set_hit,
                                            input logic clr_hit);
      busy_op_e op;
      op = BUSY_HOLD;
      if (flush_all)
         op = BUSY_FLUSH;
      else if (set_hit)
         op = BUSY_SET;
      else if (clr_hit)
         op = BUSY_CLEAR;
      return op;
   endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// -----------------------------------------------------------------------------
// operand_fetch_if
// Bundles every signal operand_fetch exchanges with its neighbours:
//   in_*   decode -> operand_fetch instruction handshake
//   rf_*   register_file read addresses and read data
//   wb_*   writeback stage feedback (same cycle as the register_file write)
//   flush  synchronous pipeline kill
//   out_*  operand_fetch -> execute operand handshake
// Modports:
//   slave  the operand_fetch block itself
//   master the surrounding pipeline (decode, register_file, writeback, execute)
// -----------------------------------------------------------------------------
interface operand_fetch_if
   import operand_fetch_pkg::*;
#(
   parameter int ADDR_WIDTH = OF_ADDR_WIDTH,
   parameter int WIDTH      = OF_WIDTH
) ();

   logic                  in_valid;
   logic                  in_ready;
   logic [ADDR_WIDTH-1:0] in_rs1;
   logic [ADDR_WIDTH-1:0] in_rs2;
   logic [ADDR_WIDTH-1:0] in_rd;
   logic                  in_rd_we;

   logic [ADDR_WIDTH-1:0] rf_src1;
   logic [ADDR_WIDTH-1:0] rf_src2;
   logic [WIDTH-1:0]      rf_rdata1;
   logic [WIDTH-1:0]      rf_rdata2;

   logic                  wb_valid;
   logic [ADDR_WIDTH-1:0] wb_rd;
   logic [WIDTH-1:0]      wb_data;

   logic                  flush;

   logic                  out_valid;
   logic                  out_ready;
   logic [WIDTH-1:0]      out_op1;
   logic [WIDTH-1:0]      out_op2;
   logic [ADDR_WIDTH-1:0] out_rd;
   logic                  out_rd_we;

   modport slave (
      input  in_valid, in_rs1, in_rs2, in_rd, in_rd_we,
      output in_ready,
      output rf_src1, rf_src2,
      input  rf_rdata1, rf_rdata2,
      input  wb_valid, wb_rd, wb_data,
      input  flush,
      output out_valid, out_op1, out_op2, out_rd, out_rd_we,
      input  out_ready
   );

   modport master (
      output in_valid, in_rs1, in_rs2, in_rd, in_rd_we,
      input  in_ready,
      input  rf_src1, rf_src2,
      output rf_rdata1, rf_rdata2,
      output wb_valid, wb_rd, wb_data,
      output flush,
      input  out_valid, out_op1, out_op2, out_rd, out_rd_we,
      output out_ready
   );

endinterface

// File: rtl/operand_fetch_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// operand_fetch_reg_scoreboard
// One busy bit per register: set when an instruction that writes the register
// is accepted, cleared when its writeback arrives, all cleared by a flush.
// The lookup outputs already account for a writeback landing this cycle, so a
// register being cleared right now does not report busy.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush_all             clear every busy bit at the next edge
//   set_en, set_addr      mark a register busy
//   clr_en, clr_addr      mark a register free (writeback)
//   rd_addr1/2, waw_addr  lookup addresses
//   busy1/2, busy_waw     busy-and-not-cleared-this-cycle flags
// -----------------------------------------------------------------------------
module operand_fetch_reg_scoreboard
   import operand_fetch_pkg::*;
#(
   parameter int ADDR_WIDTH = OF_ADDR_WIDTH,
   parameter int DEPTH      = OF_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush_all,
   input  logic                  set_en,
   input  logic [ADDR_WIDTH-1:0] set_addr,
   input  logic                  clr_en,
   input  logic [ADDR_WIDTH-1:0] clr_addr,
   input  logic [ADDR_WIDTH-1:0] rd_addr1,
   input  logic [ADDR_WIDTH-1:0] rd_addr2,
   input  logic [ADDR_WIDTH-1:0] waw_addr,
   output logic                  busy1,
   output logic                  busy2,
   output logic                  busy_waw
);

   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;

   always_comb begin
      busy_d = busy_q;
      for (int r = 0; r < DEPTH; r++) begin
         unique case (busy_op_sel(flush_all,
                                  set_en && (set_addr == ADDR_WIDTH'(r)),
                                  clr_en && (clr_addr == ADDR_WIDTH'(r))))
            BUSY_FLUSH: busy_d[r] = 1'b0;
            BUSY_SET:   busy_d[r] = 1'b1;
            BUSY_CLEAR: busy_d[r] = 1'b0;
            default:    busy_d[r] = busy_q[r];
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         busy_q <= '0;
      else
         busy_q <= busy_d;
   end

   assign busy1    = busy_q[rd_addr1] && !(clr_en && (clr_addr == rd_addr1));
   assign busy2    = busy_q[rd_addr2] && !(clr_en && (clr_addr == rd_addr2));
   assign busy_waw = busy_q[waw_addr] && !(clr_en && (clr_addr == waw_addr));

endmodule

// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch
// Read-side front end of register_file. Presents the decoded source addresses
// straight to register_file, picks each operand (zero register, same-cycle
// writeback forward, or register_file read data) and captures it together with
// rd/rd_we in a one-entry output stage with a valid/ready handshake. A busy-bit
// scoreboard stalls decode on RAW and WAW hazards.
//
// Ports:
//   clk    clock, all state on posedge
//   rst_n  asynchronous active-low reset
//   bus    operand_fetch_if.slave: in_* (decode), rf_* (register_file),
//          wb_* (writeback), flush, out_* (execute)
// -----------------------------------------------------------------------------
module operand_fetch
   import operand_fetch_pkg::*;
#(
   parameter int ADDR_WIDTH = OF_ADDR_WIDTH,
   parameter int WIDTH      = OF_WIDTH,
   parameter int DEPTH      = OF_DEPTH,
   parameter bit ZERO_REG   = OF_ZERO_REG
) (
   input  logic            clk,
   input  logic            rst_n,
   operand_fetch_if.slave  bus
);

   // register_file writes land on the next edge, so a writeback in the same
   // cycle as the read must be forwarded or the operand would be stale.
   function automatic logic [WIDTH-1:0] sel_operand(
      input logic [ADDR_WIDTH-1:0] src,
      input logic [WIDTH-1:0]      rf_data,
      input logic                  wb_valid,
      input logic [ADDR_WIDTH-1:0] wb_rd,
      input logic [WIDTH-1:0]      wb_data
   );
      logic [WIDTH-1:0] v;
      if (ZERO_REG && (src == '0))
         v = '0;
      else if (wb_valid && (wb_rd == src))
         v = wb_data;
      else
         v = rf_data;
      return v;
   endfunction

   logic                  busy1, busy2, busy_waw;
   logic                  hazard;
   logic                  accept;
   logic                  set_en;
   logic [WIDTH-1:0]      op1_p0, op2_p0;

   logic                  vld_p1;
   logic [WIDTH-1:0]      op1_p1, op2_p1;
   logic [ADDR_WIDTH-1:0] rd_p1;
   logic                  rd_we_p1;

   // ---- stage 0: address, hazard check and operand select (combinational) ----
   assign bus.rf_src1 = bus.in_rs1;
   assign bus.rf_src2 = bus.in_rs2;

   assign op1_p0 = sel_operand(bus.in_rs1, bus.rf_rdata1, bus.wb_valid, bus.wb_rd, bus.wb_data);
   assign op2_p0 = sel_operand(bus.in_rs2, bus.rf_rdata2, bus.wb_valid, bus.wb_rd, bus.wb_data);

   // Register 0 is never set busy, so it can never raise a hazard.
   assign hazard = busy1 || busy2 || (bus.in_rd_we && busy_waw);

   // The output stage frees up in the same cycle execute takes it.
   assign bus.in_ready = !bus.flush && !hazard && (!vld_p1 || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;
   assign set_en       = accept && bus.in_rd_we && !(ZERO_REG && (bus.in_rd == '0));

   operand_fetch_reg_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DEPTH      (DEPTH)
   ) u_scoreboard (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush_all (bus.flush),
      .set_en    (set_en),
      .set_addr  (bus.in_rd),
      .clr_en    (bus.wb_valid),
      .clr_addr  (bus.wb_rd),
      .rd_addr1  (bus.in_rs1),
      .rd_addr2  (bus.in_rs2),
      .waw_addr  (bus.in_rd),
      .busy1     (busy1),
      .busy2     (busy2),
      .busy_waw  (busy_waw)
   );

   // ---- stage 1: one-entry output register toward execute ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1   <= 1'b0;
         op1_p1   <= '0;
         op2_p1   <= '0;
         rd_p1    <= '0;
         rd_we_p1 <= 1'b0;
      end else if (bus.flush) begin
         vld_p1 <= 1'b0;
      end else if (accept) begin
         vld_p1   <= 1'b1;
         op1_p1   <= op1_p0;
         op2_p1   <= op2_p0;
         rd_p1    <= bus.in_rd;
         rd_we_p1 <= bus.in_rd_we;
      end else if (bus.out_ready) begin
         vld_p1 <= 1'b0;
      end
   end

   assign bus.out_valid = vld_p1;
   assign bus.out_op1   = op1_p1;
   assign bus.out_op2   = op2_p1;
   assign bus.out_rd    = rd_p1;
   assign bus.out_rd_we = rd_we_p1;

endmodule
